// File: rtl/reg_cmd_engine.sv
// reg_cmd_engine: turns a command byte stream into register write strobes and
// register reads. Read data is streamed back as reply bytes. Partial frames and
// stalled reads are abandoned after TIMEOUT idle cycles.
module reg_cmd_engine #(
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned DATA_BYTES = 1,
  parameter int unsigned TIMEOUT    = 1023
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [7:0]              cmd_in,
  input  logic                    cmd_wr,
  output logic                    cmd_ready,
  output logic [ADDR_WIDTH-1:0]   reg_addr,
  output logic [8*DATA_BYTES-1:0] reg_wdata,
  output logic                    reg_wr,
  output logic                    reg_rd,
  input  logic [8*DATA_BYTES-1:0] reg_rdata,
  input  logic                    reg_rd_valid,
  output logic [7:0]              reply_data,
  output logic                    reply_wr,
  input  logic                    reply_full,
  output logic                    err_timeout,
  output logic                    err_overrun
);

  localparam int unsigned DW       = 8 * DATA_BYTES;
  localparam int unsigned CW       = 2;
  localparam int unsigned TW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned TMO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam bit          TMO_EN   = (TIMEOUT != 0);

  localparam logic [CW-1:0] LAST_BYTE = CW'(DATA_BYTES - 1);
  localparam logic [TW-1:0] TMO_END   = TW'(TMO_LAST);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_DATA    = 3'd1;
  localparam logic [2:0] S_WRITE   = 3'd2;
  localparam logic [2:0] S_RD_REQ  = 3'd3;
  localparam logic [2:0] S_RD_WAIT = 3'd4;
  localparam logic [2:0] S_REPLY   = 3'd5;

  logic [2:0]            state_q,       state_d;
  logic [ADDR_WIDTH-1:0] addr_q,        addr_d;
  logic [DW-1:0]         wdata_q,       wdata_d;
  logic [DW-1:0]         shift_q,       shift_d;
  logic [CW-1:0]         byte_cnt_q,    byte_cnt_d;
  logic [TW-1:0]         tmo_q,         tmo_d;
  logic                  reg_wr_q,      reg_wr_d;
  logic                  reg_rd_q,      reg_rd_d;
  logic                  cmd_ready_q,   cmd_ready_d;
  logic                  err_timeout_q, err_timeout_d;
  logic                  err_overrun_q, err_overrun_d;

  logic accept;
  logic tmo_hit;

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    shift_d       = shift_q;
    byte_cnt_d    = byte_cnt_q;
    tmo_d         = tmo_q;
    err_timeout_d = 1'b0;

    accept  = cmd_wr & cmd_ready_q;
    tmo_hit = TMO_EN && (tmo_q == TMO_END);

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d     = cmd_in[ADDR_WIDTH-1:0];
          byte_cnt_d = '0;
          tmo_d      = '0;
          state_d    = cmd_in[7] ? S_RD_REQ : S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          for (int unsigned i = 0; i < DATA_BYTES; i++) begin
            if (byte_cnt_q == CW'(i)) wdata_d[8*i +: 8] = cmd_in;
          end
          tmo_d = '0;
          if (byte_cnt_q == LAST_BYTE) begin
            byte_cnt_d = '0;
            state_d    = S_WRITE;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end else if (tmo_hit) begin
          // Partial frame is dropped without a write strobe
          byte_cnt_d    = '0;
          tmo_d         = '0;
          err_timeout_d = 1'b1;
          state_d       = S_IDLE;
        end else if (TMO_EN) begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_WRITE: begin
        state_d = S_IDLE;
      end
      S_RD_REQ: begin
        tmo_d   = '0;
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (reg_rd_valid) begin
          shift_d    = reg_rdata;
          byte_cnt_d = '0;
          state_d    = S_REPLY;
        end else if (tmo_hit) begin
          // Host still gets a full-length reply, all 0xFF
          shift_d       = '1;
          byte_cnt_d    = '0;
          tmo_d         = '0;
          err_timeout_d = 1'b1;
          state_d       = S_REPLY;
        end else if (TMO_EN) begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_REPLY: begin
        if (!reply_full) begin
          shift_d = shift_q >> 8;
          if (byte_cnt_q == LAST_BYTE) begin
            byte_cnt_d = '0;
            state_d    = S_IDLE;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        byte_cnt_d = '0;
        tmo_d      = '0;
        state_d    = S_IDLE;
      end
    endcase

    reg_wr_d      = (state_d == S_WRITE);
    reg_rd_d      = (state_d == S_RD_REQ);
    cmd_ready_d   = (state_d == S_IDLE) || (state_d == S_DATA);
    err_overrun_d = cmd_wr & ~cmd_ready_q;
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      shift_q       <= '0;
      byte_cnt_q    <= '0;
      tmo_q         <= '0;
      reg_wr_q      <= 1'b0;
      reg_rd_q      <= 1'b0;
      cmd_ready_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      shift_q       <= shift_d;
      byte_cnt_q    <= byte_cnt_d;
      tmo_q         <= tmo_d;
      reg_wr_q      <= reg_wr_d;
      reg_rd_q      <= reg_rd_d;
      cmd_ready_q   <= cmd_ready_d;
      err_timeout_q <= err_timeout_d;
      err_overrun_q <= err_overrun_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign reg_addr    = addr_q;
  assign reg_wdata   = wdata_q;
  assign reg_wr      = reg_wr_q;
  assign reg_rd      = reg_rd_q;
  assign reply_data  = shift_q[7:0];
  // Reply handshake follows the sink directly so a byte moves every free cycle
  assign reply_wr    = (state_q == S_REPLY) && !reply_full;
  assign err_timeout = err_timeout_q;
  assign err_overrun = err_overrun_q;

endmodule

// File: tb/tb_reg_cmd_engine.sv
// Directed bench for reg_cmd_engine: u1 has one data byte, u2 has two; both time out after 16 idle cycles.
module tb_reg_cmd_engine;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [7:0] cmd_in = 8'h00;
  logic wr1 = 1'b0, wr2 = 1'b0;
  logic reply_full = 1'b0;
  logic [7:0]  rdata1 = 8'h00;
  logic [15:0] rdata2 = 16'h0000;
  logic rdv1 = 1'b0, rdv2 = 1'b0;

  logic       cmd_ready1, reg_wr1, reg_rd1, reply_wr1, err_to1, err_ov1;
  logic [6:0] addr1;
  logic [7:0] wdata1, reply_data1;
  logic        cmd_ready2, reg_wr2, reg_rd2, reply_wr2, err_to2, err_ov2;
  logic [6:0]  addr2;
  logic [15:0] wdata2;
  logic [7:0]  reply_data2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  reg_cmd_engine #(.ADDR_WIDTH(7), .DATA_BYTES(1), .TIMEOUT(16)) u1 (
    .clk(clk), .reset_n(reset_n), .cmd_in(cmd_in), .cmd_wr(wr1), .cmd_ready(cmd_ready1),
    .reg_addr(addr1), .reg_wdata(wdata1), .reg_wr(reg_wr1), .reg_rd(reg_rd1),
    .reg_rdata(rdata1), .reg_rd_valid(rdv1), .reply_data(reply_data1), .reply_wr(reply_wr1),
    .reply_full(reply_full), .err_timeout(err_to1), .err_overrun(err_ov1)
  );

  reg_cmd_engine #(.ADDR_WIDTH(7), .DATA_BYTES(2), .TIMEOUT(16)) u2 (
    .clk(clk), .reset_n(reset_n), .cmd_in(cmd_in), .cmd_wr(wr2), .cmd_ready(cmd_ready2),
    .reg_addr(addr2), .reg_wdata(wdata2), .reg_wr(reg_wr2), .reg_rd(reg_rd2),
    .reg_rdata(rdata2), .reg_rd_valid(rdv2), .reply_data(reply_data2), .reply_wr(reply_wr2),
    .reply_full(reply_full), .err_timeout(err_to2), .err_overrun(err_ov2)
  );

  // Advance to just after the next rising edge (drive point)
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) cyc();
    #2;
    n_vec++; if ({reg_wr1, reg_rd1, reply_wr1, err_to1, err_ov1, cmd_ready1} !== 6'b0) begin n_err++; $display("FAIL reset_ctl1: got %b exp 000000", {reg_wr1, reg_rd1, reply_wr1, err_to1, err_ov1, cmd_ready1}); end
    n_vec++; if ({addr1, wdata1, reply_data1} !== 23'h0) begin n_err++; $display("FAIL reset_data1: got %h exp 0", {addr1, wdata1, reply_data1}); end
    n_vec++; if ({reg_wr2, reg_rd2, reply_wr2, err_to2, err_ov2, cmd_ready2} !== 6'b0) begin n_err++; $display("FAIL reset_ctl2: got %b exp 000000", {reg_wr2, reg_rd2, reply_wr2, err_to2, err_ov2, cmd_ready2}); end
    n_vec++; if ({addr2, wdata2, reply_data2} !== 31'h0) begin n_err++; $display("FAIL reset_data2: got %h exp 0", {addr2, wdata2, reply_data2}); end
    cyc(); reset_n = 1'b1;
    cyc(); cyc(); #2;
    n_vec++; if (cmd_ready1 !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b exp 1", cmd_ready1); end
  endtask

  task automatic test_write_single();
    cyc(); cmd_in = 8'h05; wr1 = 1'b1;
    cyc(); cmd_in = 8'hA5; #2;
    n_vec++; if (reg_wr1 !== 1'b0) begin n_err++; $display("FAIL wr1_hdr_nostrobe: got %b exp 0", reg_wr1); end
    cyc(); wr1 = 1'b0; #2;
    n_vec++; if (reg_wr1 !== 1'b1) begin n_err++; $display("FAIL wr1_strobe: got %b exp 1", reg_wr1); end
    n_vec++; if (addr1 !== 7'h05) begin n_err++; $display("FAIL wr1_addr: got %h exp 05", addr1); end
    n_vec++; if (wdata1 !== 8'hA5) begin n_err++; $display("FAIL wr1_data: got %h exp a5", wdata1); end
    n_vec++; if (reg_rd1 !== 1'b0) begin n_err++; $display("FAIL wr1_no_rd: got %b exp 0", reg_rd1); end
    cyc(); #2;
    n_vec++; if (reg_wr1 !== 1'b0) begin n_err++; $display("FAIL wr1_single_pulse: got %b exp 0", reg_wr1); end
    n_vec++; if ({addr1, wdata1} !== {7'h05, 8'hA5}) begin n_err++; $display("FAIL wr1_hold: got %h exp %h", {addr1, wdata1}, {7'h05, 8'hA5}); end
  endtask

  task automatic test_read_backpressure();
    cyc(); cmd_in = 8'h83; wr2 = 1'b1;
    cyc(); wr2 = 1'b0; #2;
    n_vec++; if (reg_rd2 !== 1'b1) begin n_err++; $display("FAIL rd_strobe: got %b exp 1", reg_rd2); end
    n_vec++; if (addr2 !== 7'h03) begin n_err++; $display("FAIL rd_addr: got %h exp 03", addr2); end
    n_vec++; if (reg_wr2 !== 1'b0) begin n_err++; $display("FAIL rd_no_wr: got %b exp 0", reg_wr2); end
    cyc(); #2;
    n_vec++; if (reg_rd2 !== 1'b0) begin n_err++; $display("FAIL rd_single_pulse: got %b exp 0", reg_rd2); end
    cyc();
    cyc(); rdata2 = 16'hBEEF; rdv2 = 1'b1; reply_full = 1'b1;
    cyc(); rdv2 = 1'b0; rdata2 = 16'h0000; #2;
    n_vec++; if (reply_data2 !== 8'hEF) begin n_err++; $display("FAIL rd_first_byte_held: got %h exp ef", reply_data2); end
    for (int k = 0; k < 5; k++) begin
      if (k != 0) begin cyc(); #2; end
      n_vec++; if (reply_wr2 !== 1'b0) begin n_err++; $display("FAIL rd_full_stall%0d: got %b exp 0", k, reply_wr2); end
    end
    cyc(); reply_full = 1'b0; #2;
    n_vec++; if ({reply_wr2, reply_data2} !== {1'b1, 8'hEF}) begin n_err++; $display("FAIL rd_byte0: got %h exp 1ef", {reply_wr2, reply_data2}); end
    cyc(); #2;
    n_vec++; if ({reply_wr2, reply_data2} !== {1'b1, 8'hBE}) begin n_err++; $display("FAIL rd_byte1: got %h exp 1be", {reply_wr2, reply_data2}); end
    cyc(); #2;
    n_vec++; if ({reply_wr2, cmd_ready2} !== 2'b01) begin n_err++; $display("FAIL rd_done: got %b exp 01", {reply_wr2, cmd_ready2}); end
  endtask

  task automatic test_write_timeout();
    cyc(); cmd_in = 8'h01; wr1 = 1'b1;
    cyc(); wr1 = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      cyc(); #2;
      n_vec++; if (err_to1 !== 1'b0) begin n_err++; $display("FAIL wto_early_c%0d: got %b exp 0", k, err_to1); end
    end
    cyc(); #2;
    n_vec++; if (err_to1 !== 1'b1) begin n_err++; $display("FAIL wto_pulse: got %b exp 1", err_to1); end
    n_vec++; if (reg_wr1 !== 1'b0) begin n_err++; $display("FAIL wto_no_wr: got %b exp 0", reg_wr1); end
    cyc(); #2;
    n_vec++; if ({err_to1, reg_wr1, cmd_ready1} !== 3'b001) begin n_err++; $display("FAIL wto_after: got %b exp 001", {err_to1, reg_wr1, cmd_ready1}); end
    cmd_in = 8'h02; wr1 = 1'b1;
    cyc(); cmd_in = 8'h33;
    cyc(); wr1 = 1'b0; #2;
    n_vec++; if ({reg_wr1, addr1, wdata1} !== {1'b1, 7'h02, 8'h33}) begin n_err++; $display("FAIL wto_next_frame: got %h exp %h", {reg_wr1, addr1, wdata1}, {1'b1, 7'h02, 8'h33}); end
  endtask

  task automatic test_read_timeout();
    cyc(); cmd_in = 8'h84; wr2 = 1'b1;
    cyc(); wr2 = 1'b0; #2;
    n_vec++; if ({reg_rd2, addr2} !== {1'b1, 7'h04}) begin n_err++; $display("FAIL rto_req: got %h exp %h", {reg_rd2, addr2}, {1'b1, 7'h04}); end
    for (int k = 1; k <= 16; k++) begin
      cyc(); #2;
      n_vec++; if ({err_to2, reply_wr2} !== 2'b00) begin n_err++; $display("FAIL rto_early_c%0d: got %b exp 00", k, {err_to2, reply_wr2}); end
    end
    cyc(); #2;
    n_vec++; if ({err_to2, reply_wr2, reply_data2} !== {2'b11, 8'hFF}) begin n_err++; $display("FAIL rto_byte0: got %h exp 3ff", {err_to2, reply_wr2, reply_data2}); end
    cyc(); #2;
    n_vec++; if ({err_to2, reply_wr2, reply_data2} !== {2'b01, 8'hFF}) begin n_err++; $display("FAIL rto_byte1: got %h exp 1ff", {err_to2, reply_wr2, reply_data2}); end
    cyc(); #2;
    n_vec++; if ({reply_wr2, cmd_ready2} !== 2'b01) begin n_err++; $display("FAIL rto_done: got %b exp 01", {reply_wr2, cmd_ready2}); end
  endtask

  task automatic test_overrun();
    cyc(); cmd_in = 8'h07; wr1 = 1'b1;
    cyc(); cmd_in = 8'h5A;
    cyc(); cmd_in = 8'h99; #2;
    n_vec++; if ({reg_wr1, cmd_ready1, wdata1} !== {2'b10, 8'h5A}) begin n_err++; $display("FAIL ovr_write: got %h exp %h", {reg_wr1, cmd_ready1, wdata1}, {2'b10, 8'h5A}); end
    cyc(); wr1 = 1'b0; #2;
    n_vec++; if (err_ov1 !== 1'b1) begin n_err++; $display("FAIL ovr_pulse: got %b exp 1", err_ov1); end
    n_vec++; if (addr1 !== 7'h07) begin n_err++; $display("FAIL ovr_dropped: got %h exp 07", addr1); end
    cyc(); #2;
    n_vec++; if ({err_ov1, cmd_ready1} !== 2'b01) begin n_err++; $display("FAIL ovr_after: got %b exp 01", {err_ov1, cmd_ready1}); end
    cmd_in = 8'h0A; wr1 = 1'b1;
    cyc(); cmd_in = 8'h3C;
    cyc(); wr1 = 1'b0; #2;
    n_vec++; if ({reg_wr1, addr1, wdata1} !== {1'b1, 7'h0A, 8'h3C}) begin n_err++; $display("FAIL ovr_next_frame: got %h exp %h", {reg_wr1, addr1, wdata1}, {1'b1, 7'h0A, 8'h3C}); end
  endtask

  task automatic test_reset_mid_frame();
    cyc(); cmd_in = 8'h11; wr2 = 1'b1;
    cyc(); cmd_in = 8'h22;
    cyc(); wr2 = 1'b0; reset_n = 1'b0; #2;
    n_vec++; if ({reg_wr2, reg_rd2, cmd_ready2, addr2, wdata2} !== 26'h0) begin n_err++; $display("FAIL rst_mid_out: got %h exp 0", {reg_wr2, reg_rd2, cmd_ready2, addr2, wdata2}); end
    cyc(); #2;
    n_vec++; if (reg_wr2 !== 1'b0) begin n_err++; $display("FAIL rst_mid_no_wr: got %b exp 0", reg_wr2); end
    reset_n = 1'b1;
    cyc(); cyc(); #2;
    n_vec++; if (reg_wr2 !== 1'b0) begin n_err++; $display("FAIL rst_mid_no_wr_after: got %b exp 0", reg_wr2); end
    cmd_in = 8'h15; wr2 = 1'b1;
    cyc(); cmd_in = 8'h34;
    cyc(); cmd_in = 8'h12;
    cyc(); wr2 = 1'b0; #2;
    n_vec++; if ({reg_wr2, addr2, wdata2} !== {1'b1, 7'h15, 16'h1234}) begin n_err++; $display("FAIL rst_mid_next_frame: got %h exp %h", {reg_wr2, addr2, wdata2}, {1'b1, 7'h15, 16'h1234}); end
  endtask

  initial begin
    test_reset();
    test_write_single();
    test_read_backpressure();
    test_write_timeout();
    test_read_timeout();
    test_overrun();
    test_reset_mid_frame();
    repeat (2) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
